// File: rtl/jtag_tap_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtag_tap_master_pkg                                          |
// | Description : Shared definitions for the JTAG TAP master: command op       |
// |               codes, controller state encodings and the fixed TMS walk     |
// |               sequences used to move the target TAP between states.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package jtag_tap_master_pkg;

  // Command op codes carried on req_op_i
  typedef enum logic [1:0] {
    JTAG_OP_RST = 2'b00,
    JTAG_OP_IR  = 2'b01,
    JTAG_OP_DR  = 2'b10,
    JTAG_OP_NOP = 2'b11
  } jtag_op_e;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_PRE   = 3'd2,
    S_SHIFT = 3'd3,
    S_POST  = 3'd4,
    S_RTI   = 3'd5,
    S_DONE  = 3'd6
  } jtag_state_e;

  // TMS sequences, bit i is the TMS value of the i-th TCK of the walk.
  // Reset: five ones reach Test-Logic-Reset from anywhere, one zero to Idle.
  localparam logic [7:0] JTAG_TMS_RST    = 8'b0001_1111;
  localparam int         JTAG_RST_LEN    = 6;
  // Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [7:0] JTAG_TMS_PRE_IR = 8'b0000_0011;
  localparam int         JTAG_PRE_IR_LEN = 4;
  // Idle -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [7:0] JTAG_TMS_PRE_DR = 8'b0000_0001;
  localparam int         JTAG_PRE_DR_LEN = 3;
  // Exit1 -> Update -> Idle
  localparam logic [7:0] JTAG_TMS_POST   = 8'b0000_0001;
  localparam int         JTAG_POST_LEN   = 2;

  // Pick one TMS bit out of a walk sequence
  function automatic logic jtag_seq_bit(input logic [7:0] seq, input logic [2:0] idx);
    return seq[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_master_tck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtag_tck_gen                                                 |
// | Description : TCK divider. Each TCK bit is CLK_DIV clks low followed by    |
// |               CLK_DIV clks high. While disabled TCK is held low and the    |
// |               divider restarts at the beginning of a low phase.            |
// | Ports       : clk, rst (sync, active-low), en_i                            |
// |               tck_o         - test clock                                   |
// |               fall_tick_o   - first clk of the low phase                   |
// |               sample_tick_o - last clk of the low phase (TDO sample point) |
// |               end_tick_o    - last clk of the high phase (bit boundary)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtag_tck_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tck_o,
  output logic fall_tick_o,
  output logic sample_tick_o,
  output logic end_tick_o
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       tck_q;
  logic       w_cnt_last;

  assign w_cnt_last    = (cnt_q == CNT_LAST);
  assign fall_tick_o   = en_i && !tck_q && (cnt_q == 8'd0);
  assign sample_tick_o = en_i && !tck_q && w_cnt_last;
  assign end_tick_o    = en_i &&  tck_q && w_cnt_last;
  assign tck_o         = tck_q;

  always_ff @(posedge clk) begin
    if (!rst || !en_i) begin
      cnt_q <= 8'd0;
      tck_q <= 1'b0;
    end else if (w_cnt_last) begin
      cnt_q <= 8'd0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtag_tap_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtag_tap_master                                              |
// | Description : JTAG TAP master. Accepts TAP-reset / IR-scan / DR-scan       |
// |               commands on a valid/ready interface, walks the target TAP    |
// |               and returns the TDO bits captured during the scan.           |
// |               An automatic TAP reset runs after rst releases.              |
// | Config      : JTAG_TDO_SYNC_EN - when defined, jtag_TDO_i goes through a   |
// |               2-flop synchroniser (needs CLK_DIV >= 3).                    |
// | Ports       : clk, rst (sync, active-low)                                  |
// |               req_valid_i/req_ready_o/req_op_i/req_data_i - command        |
// |               resp_valid_o/resp_data_o - completion pulse and TDO data     |
// |               jtag_TCK_o/jtag_TMS_o/jtag_TDI_o/jtag_TDO_i - JTAG pins      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtag_tap_master
  import jtag_tap_master_pkg::*;
#(
  parameter int CLK_DIV     = 5,
  parameter int IR_WIDTH    = 5,
  parameter int DR_WIDTH    = 40,
  parameter int IDLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_op_i,
  input  logic [DR_WIDTH-1:0] req_data_i,
  output logic                resp_valid_o,
  output logic [DR_WIDTH-1:0] resp_data_o,
  output logic                jtag_TCK_o,
  output logic                jtag_TMS_o,
  output logic                jtag_TDI_o,
  input  logic                jtag_TDO_i
);

  localparam int CNT_W = $clog2(DR_WIDTH + 1);

  jtag_state_e         state_q;
  logic                boot_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic [DR_WIDTH-1:0] resp_data_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] shift_d;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                is_ir_q;
  logic                tms_q;
  logic                tdi_q;

  logic                w_scan;
  logic                w_fall;
  logic                w_sample;
  logic                w_end;
  logic                w_tdo;
  logic                w_tms;
  logic [CNT_W-1:0]    w_len;
  logic                w_last_bit;

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_clk_div_range
    $error("jtag_tap_master: CLK_DIV must be in 2..255");
  end

`ifdef JTAG_TDO_SYNC_EN
  logic [1:0] tdo_sync_q;

  if (CLK_DIV < 3) begin : g_clk_div_sync
    $error("jtag_tap_master: CLK_DIV must be >= 3 with the TDO synchroniser");
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tdo_sync_q <= 2'b00;
    end else begin
      tdo_sync_q <= {tdo_sync_q[0], jtag_TDO_i};
    end
  end
  assign w_tdo = tdo_sync_q[1];
`else
  assign w_tdo = jtag_TDO_i;
`endif

  // TCK only runs while the controller is walking the TAP
  assign w_scan = (state_q == S_RST) || (state_q == S_PRE) || (state_q == S_SHIFT) ||
                  (state_q == S_POST) || (state_q == S_RTI);

  jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk          (clk),
    .rst          (rst),
    .en_i         (w_scan),
    .tck_o        (jtag_TCK_o),
    .fall_tick_o  (w_fall),
    .sample_tick_o(w_sample),
    .end_tick_o   (w_end)
  );

  // Length of the current state's TCK walk and the TMS value for this bit
  always_comb begin
    w_len = '0;
    w_tms = 1'b0;
    case (state_q)
      S_RST: begin
        w_len = CNT_W'(JTAG_RST_LEN);
        w_tms = jtag_seq_bit(JTAG_TMS_RST, bit_cnt_q[2:0]);
      end
      S_PRE: begin
        if (is_ir_q) begin
          w_len = CNT_W'(JTAG_PRE_IR_LEN);
          w_tms = jtag_seq_bit(JTAG_TMS_PRE_IR, bit_cnt_q[2:0]);
        end else begin
          w_len = CNT_W'(JTAG_PRE_DR_LEN);
          w_tms = jtag_seq_bit(JTAG_TMS_PRE_DR, bit_cnt_q[2:0]);
        end
      end
      S_SHIFT: begin
        w_len = is_ir_q ? CNT_W'(IR_WIDTH) : CNT_W'(DR_WIDTH);
        // Leave Shift-xR on the last data bit
        w_tms = (bit_cnt_q == w_len - CNT_W'(1));
      end
      S_POST: begin
        w_len = CNT_W'(JTAG_POST_LEN);
        w_tms = jtag_seq_bit(JTAG_TMS_POST, bit_cnt_q[2:0]);
      end
      S_RTI: begin
        w_len = CNT_W'(IDLE_CYCLES);
        w_tms = 1'b0;
      end
      default: begin
        w_len = '0;
        w_tms = 1'b0;
      end
    endcase
  end

  assign w_last_bit = (bit_cnt_q == w_len - CNT_W'(1));

  // Shift right with TDO entering at the top of the active length so the
  // first captured bit ends at [0]; upper bits stay zero for IR scans.
  always_comb begin
    if (is_ir_q) begin
      shift_d = DR_WIDTH'({w_tdo, shift_q[IR_WIDTH-1:1]});
    end else begin
      shift_d = {w_tdo, shift_q[DR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      boot_q       <= 1'b1;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      is_ir_q      <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b1;
    end else begin
      resp_valid_q <= 1'b0;
      if (w_scan) begin
        if (w_fall) begin
          tms_q <= w_tms;
          tdi_q <= (state_q == S_SHIFT) ? shift_q[0] : 1'b1;
        end
        if (w_sample && (state_q == S_SHIFT)) begin
          shift_q <= shift_d;
        end
        if (w_end) begin
          if (!w_last_bit) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else begin
            bit_cnt_q <= '0;
            case (state_q)
              S_RST: begin
                if (boot_q) begin
                  // Power-up reset walk: no response, just open for commands
                  boot_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
                end else begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= shift_q;
                  state_q      <= S_DONE;
                end
              end
              S_PRE:   state_q <= S_SHIFT;
              S_SHIFT: state_q <= S_POST;
              S_POST: begin
                if (IDLE_CYCLES > 0) begin
                  state_q <= S_RTI;
                end else begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= shift_q;
                  state_q      <= S_DONE;
                end
              end
              default: begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= shift_q;
                state_q      <= S_DONE;
              end
            endcase
          end
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            tms_q     <= 1'b0;
            bit_cnt_q <= '0;
            if (boot_q) begin
              state_q <= S_RST;
            end else if (ready_q && req_valid_i) begin
              ready_q <= 1'b0;
              case (req_op_i)
                JTAG_OP_RST: begin
                  shift_q <= '0;
                  state_q <= S_RST;
                end
                JTAG_OP_IR: begin
                  shift_q <= DR_WIDTH'(req_data_i[IR_WIDTH-1:0]);
                  is_ir_q <= 1'b1;
                  state_q <= S_PRE;
                end
                JTAG_OP_DR: begin
                  shift_q <= req_data_i;
                  is_ir_q <= 1'b0;
                  state_q <= S_PRE;
                end
                default: begin
                  // Reserved op completes immediately without touching TCK
                  shift_q      <= '0;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= '0;
                  state_q      <= S_DONE;
                end
              endcase
            end
          end
          default: begin
            tms_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign jtag_TMS_o   = tms_q;
  assign jtag_TDI_o   = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtag_tap_master                                           |
// | Description : Directed bench for jtag_tap_master. A behavioural TAP with   |
// |               TDO looped back from TDI (one TCK late) sits on the pins.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtag_tap_master;
  import jtag_tap_master_pkg::*;

  localparam int CLK_DIV  = 5;
  localparam int DR_WIDTH = 40;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid = 1'b0;
  logic [1:0]          req_op = 2'b00;
  logic [DR_WIDTH-1:0] req_data = '0;
  logic                req_ready_o;
  logic                resp_valid_o;
  logic [DR_WIDTH-1:0] resp_data_o;
  logic                jtag_TCK_o;
  logic                jtag_TMS_o;
  logic                jtag_TDI_o;
  logic                tdo_q = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  jtag_tap_master #(
    .CLK_DIV(CLK_DIV), .IR_WIDTH(5), .DR_WIDTH(DR_WIDTH), .IDLE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op),
    .req_data_i  (req_data),
    .resp_valid_o(resp_valid_o),
    .resp_data_o (resp_data_o),
    .jtag_TCK_o  (jtag_TCK_o),
    .jtag_TMS_o  (jtag_TMS_o),
    .jtag_TDI_o  (jtag_TDI_o),
    .jtag_TDO_i  (tdo_q)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural target TAP ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPDIR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      T_TLR:   return tms ? T_TLR   : T_RTI;
      T_RTI:   return tms ? T_SELDR : T_RTI;
      T_SELDR: return tms ? T_SELIR : T_CAPDR;
      T_CAPDR: return tms ? T_EX1DR : T_SHDR;
      T_SHDR:  return tms ? T_EX1DR : T_SHDR;
      T_EX1DR: return tms ? T_UPDDR : T_PADR;
      T_PADR:  return tms ? T_EX2DR : T_PADR;
      T_EX2DR: return tms ? T_UPDDR : T_SHDR;
      T_UPDDR: return tms ? T_SELDR : T_RTI;
      T_SELIR: return tms ? T_TLR   : T_CAPIR;
      T_CAPIR: return tms ? T_EX1IR : T_SHIR;
      T_SHIR:  return tms ? T_EX1IR : T_SHIR;
      T_EX1IR: return tms ? T_UPDIR : T_PAIR;
      T_PAIR:  return tms ? T_EX2IR : T_PAIR;
      T_EX2IR: return tms ? T_UPDIR : T_SHIR;
      default: return tms ? T_SELDR : T_RTI;
    endcase
  endfunction

  tap_e          tap_q = T_SHDR;
  logic [4:0]    ir_sh = '0;
  logic [4:0]    ir_reg = '0;
  logic [39:0]   dr_sh = '0;
  logic [39:0]   dr_reg = '0;
  int            tck_rises = 0;
  int            resp_cnt = 0;

  always @(posedge jtag_TCK_o) begin
    case (tap_q)
      T_SHIR:  ir_sh  <= {jtag_TDI_o, ir_sh[4:1]};
      T_SHDR:  dr_sh  <= {jtag_TDI_o, dr_sh[39:1]};
      T_UPDIR: ir_reg <= ir_sh;
      T_UPDDR: dr_reg <= dr_sh;
      T_TLR:   ir_reg <= 5'h01;
      default: ;
    endcase
    tap_q     <= tap_next(tap_q, jtag_TMS_o);
    tdo_q     <= jtag_TDI_o;
    tck_rises <= tck_rises + 1;
  end

  always @(posedge clk) begin
    if (resp_valid_o) resp_cnt <= resp_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int base_rises;

  task automatic boot_check(input string tag);
    int n;
    int r0;
    r0 = tck_rises;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!req_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_clks"}, 64'(n), 64'(12 * CLK_DIV + 1));
    check_eq({tag, "_tck"}, 64'(tck_rises - r0), 64'd6);
    check_eq({tag, "_tap_idle"}, 64'(tap_q), 64'(T_RTI));
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [39:0] data);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_in_time", 64'(n < 200), 64'd1);
    @(posedge clk);
    base_rises = tck_rises;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = '1;
  endtask

  // Waits for the completion pulse; returns clks waited after the accept
  task automatic wait_resp(input string tag, output int clks, output logic [39:0] data);
    int n;
    n = 0;
    while (!resp_valid_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_resp_in_time"}, 64'(n < 2000), 64'd1);
    clks = n;
    data = resp_data_o;
    @(negedge clk);
    check_eq({tag, "_pulse_1clk"}, 64'(resp_valid_o), 64'd0);
    check_eq({tag, "_ready_after"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int          clks;
    logic [39:0] rd;
    int          n;
    int          rc0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_tck", 64'(jtag_TCK_o), 64'd0);
    check_eq("rst_tms", 64'(jtag_TMS_o), 64'd1);
    check_eq("rst_tdi", 64'(jtag_TDI_o), 64'd1);
    check_eq("rst_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_rvalid", 64'(resp_valid_o), 64'd0);
    check_eq("rst_rdata", 64'(resp_data_o), 64'd0);

    boot_check("boot");
    check_eq("boot_no_resp", 64'(resp_cnt), 64'd0);

    // IR scan: loopback returns {data[3:0], 1}
    send_cmd(JTAG_OP_IR, 40'h11);
    wait_resp("ir", clks, rd);
    check_eq("ir_resp", 64'(rd), 64'h03);
    check_eq("ir_reg", 64'(ir_reg), 64'h11);
    check_eq("ir_tck", 64'(tck_rises - base_rises), 64'd15);
    check_eq("ir_tap_idle", 64'(tap_q), 64'(T_RTI));

    // DR scan, DMI style word
    send_cmd(JTAG_OP_DR, 40'h40_0000_0002);
    wait_resp("dr1", clks, rd);
    check_eq("dr1_reg", 64'(dr_reg), 64'h40_0000_0002);
    check_eq("dr1_resp", 64'(rd), 64'h80_0000_0005);
    check_eq("dr1_tck", 64'(tck_rises - base_rises), 64'd49);

    // DR scan, loopback pattern
    send_cmd(JTAG_OP_DR, 40'hA5_1234_5678);
    wait_resp("dr2", clks, rd);
    check_eq("dr2_reg", 64'(dr_reg), 64'hA5_1234_5678);
    check_eq("dr2_resp", 64'(rd), 64'h4A_2468_ACF1);

    // Response data holds until the next completion
    repeat (5) @(negedge clk);
    check_eq("hold_rdata", 64'(resp_data_o), 64'h4A_2468_ACF1);

    // TAP reset command
    send_cmd(JTAG_OP_RST, 40'hFF_FFFF_FFFF);
    wait_resp("tapr", clks, rd);
    check_eq("tapr_resp", 64'(rd), 64'd0);
    check_eq("tapr_tck", 64'(tck_rises - base_rises), 64'd6);
    check_eq("tapr_tap_idle", 64'(tap_q), 64'(T_RTI));
    check_eq("tapr_ir_reset", 64'(ir_reg), 64'h01);

    // Reserved op after a nonzero result: immediate response of zero
    send_cmd(JTAG_OP_DR, 40'h40_0000_0002);
    wait_resp("dr3", clks, rd);
    check_eq("dr3_resp", 64'(rd), 64'h80_0000_0005);
    send_cmd(JTAG_OP_NOP, 40'hFF_FFFF_FFFF);
    wait_resp("nop", clks, rd);
    check_eq("nop_latency", 64'(clks), 64'd0);
    check_eq("nop_resp", 64'(rd), 64'd0);
    check_eq("nop_tck", 64'(tck_rises - base_rises), 64'd0);

    // Reset in the middle of a DR shift (after 20 data bits)
    rc0 = resp_cnt;
    send_cmd(JTAG_OP_DR, 40'hA5_1234_5678);
    n = 0;
    while ((tck_rises - base_rises) < 23 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_reached", 64'(n < 2000), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_tck", 64'(jtag_TCK_o), 64'd0);
    check_eq("mid_tms", 64'(jtag_TMS_o), 64'd1);
    check_eq("mid_tdi", 64'(jtag_TDI_o), 64'd1);
    check_eq("mid_ready", 64'(req_ready_o), 64'd0);
    check_eq("mid_rvalid", 64'(resp_valid_o), 64'd0);
    repeat (3) @(negedge clk);
    boot_check("reboot");
    repeat (4) @(negedge clk);
    check_eq("mid_no_resp", 64'(resp_cnt - rc0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
